// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit bus processor fetch path:
// opcode field values, fetch FSM state encoding and default word width.
package proc_pkg;

    localparam int P_DATA_W = 9;

    localparam logic [2:0] MV  = 3'b000;
    localparam logic [2:0] MVI = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_LATCH     = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_LATCH_IMM = 3'd4,
        S_RUN       = 3'd5,
        S_WAIT      = 3'd6
    } state_t;

    function automatic logic op_is_mvi(input logic [2:0] op);
        return op == MVI;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction ROM port plus the processor DIN/Run/Done link.
// Optional Step input exists only when FETCH_STEP_EN is defined.
interface instr_fetch_if #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 5
);
    logic              enable;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] din;
    logic              run;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
`ifdef FETCH_STEP_EN
    logic              step;

    modport master (
        input  enable, mem_data, done, step,
        output mem_addr, din, run, pc, busy
    );
    modport slave (
        output enable, mem_data, done, step,
        input  mem_addr, din, run, pc, busy
    );
`else
    modport master (
        input  enable, mem_data, done,
        output mem_addr, din, run, pc, busy
    );
    modport slave (
        output enable, mem_data, done,
        input  mem_addr, din, run, pc, busy
    );
`endif
endinterface

// File: rtl/pc_counter.sv
// Program counter: loads RESET_PC on reset, advances by 1 or 2,
// wrapping naturally modulo 2^ADDR_W.
module pc_counter #(
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_adv,
    input  logic              i_two,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_inc1
);
    logic [ADDR_W-1:0] r_pc;

    // Advance on instruction completion; width wrap gives the modulo.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else if (i_adv) begin
            r_pc <= r_pc + (i_two ? ADDR_W'(2) : ADDR_W'(1));
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_inc1 = r_pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: walks PC through a registered-output ROM and issues words.
// Define FETCH_STEP_EN to add single-step control through bus.step.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int DATA_W   = P_DATA_W,
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    instr_fetch_if.master bus
);
    state_t            r_state;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_din;
    logic              r_run;

    logic              w_adv;
    logic              w_ir_mvi;
    logic              w_mem_mvi;
    logic              w_start;
    logic              w_cont;
    logic              w_imm_ph;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc1;

    assign w_ir_mvi  = op_is_mvi(r_ir[DATA_W-1 -: 3]);
    assign w_mem_mvi = op_is_mvi(bus.mem_data[DATA_W-1 -: 3]);
    assign w_adv     = bus.done
                     & ((r_state == S_RUN) | (r_state == S_WAIT));
    assign w_imm_ph  = (r_state == S_FETCH_IMM)
                     | (r_state == S_LATCH_IMM);

`ifdef FETCH_STEP_EN
    assign w_start = bus.enable & bus.step;
    assign w_cont  = 1'b0;
`else
    assign w_start = bus.enable;
    assign w_cont  = bus.enable;
`endif

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_adv     (w_adv),
        .i_two     (w_ir_mvi),
        .o_pc      (w_pc),
        .o_pc_inc1 (w_pc1)
    );

    // Fetch FSM with registered Run/DIN; Run is high only in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_imm   <= '0;
            r_din   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_ir <= bus.mem_data;
                    if (w_mem_mvi) begin
                        r_state <= S_FETCH_IMM;
                    end else begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                        r_din   <= bus.mem_data;
                    end
                end
                S_FETCH_IMM: begin
                    r_state <= S_LATCH_IMM;
                end
                S_LATCH_IMM: begin
                    r_imm   <= bus.mem_data;
                    r_state <= S_RUN;
                    r_run   <= 1'b1;
                    r_din   <= r_ir;
                end
                S_RUN: begin
                    if (bus.done) begin
                        r_state <= w_cont ? S_FETCH : S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                        r_din   <= w_ir_mvi ? r_imm : r_ir;
                    end
                end
                S_WAIT: begin
                    if (bus.done) begin
                        r_state <= w_cont ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr = i_rst    ? ADDR_W'(RESET_PC)
                        : w_imm_ph ? w_pc1 : w_pc;
    assign bus.din      = i_rst ? '0 : r_din;
    assign bus.run      = r_run & ~i_rst;
    assign bus.busy     = ~i_rst & (r_state != S_IDLE);
    assign bus.pc       = w_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: ROM model, directed and random
// instruction streams checked against a per-instruction PC/latency model.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam int DW = 9;
    localparam int AW = 5;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] mem [NW];

    int checks = 0;
    int errors = 0;
    int exp_pc = 0;

    instr_fetch_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    instr_fetch #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC (0)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Registered-output instruction ROM.
    always @(posedge clk) bus.mem_data <= mem[bus.mem_addr];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] non_mvi(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = w;
        if (r[8:6] == 3'b001) r[8:6] = 3'b010;
        return r;
    endfunction

    // One instruction: place it in ROM, find the Run pulse, hold in
    // WAIT for d cycles, raise Done, then check the PC advance.
    task automatic issue(input logic [DW-1:0] word,
                         input logic [DW-1:0] imm,
                         input bit from_idle,
                         input int d,
                         input bit drop_en);
        bit mvi;
        bit got;
        int n;
        int lat;
        logic [DW-1:0] hold;
        mvi = (word[8:6] == 3'b001);
        mem[exp_pc] = word;
        if (mvi) mem[(exp_pc + 1) % NW] = imm;
        hold = mvi ? imm : word;
        lat = (from_idle ? 3 : 2) + (mvi ? 2 : 0);
        if (from_idle) bus.enable = 1'b1;
        n = 0;
        got = 0;
        while (n < 8 && !got) begin
            tick();
            n++;
            if (mvi && n == lat - 2)
                chk("imm_addr", bus.mem_addr, (exp_pc + 1) % NW);
            if (bus.run) got = 1;
        end
        chk("run_latency", n, lat);
        chk("run_din", bus.din, word);
        for (int i = 0; i < d; i++) begin
            tick();
            chk("wait_run", bus.run, 0);
            chk("wait_din", bus.din, hold);
            chk("wait_busy", bus.busy, 1);
            if (drop_en && i == 0) bus.enable = 1'b0;
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        exp_pc = (exp_pc + (mvi ? 2 : 1)) % NW;
        chk("pc_after", bus.pc, exp_pc);
        chk("addr_after", bus.mem_addr, exp_pc);
        chk("run_after", bus.run, 0);
        chk("busy_after", bus.busy, drop_en ? 0 : 1);
    endtask

    initial begin
        int it;
        int runs;
        logic [DW-1:0] w;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.done = 1'b0;
`ifdef FETCH_STEP_EN
        bus.step = 1'b0;
`endif
        tick();
        chk("rst_run", bus.run, 0);
        chk("rst_din", bus.din, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.mem_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_run", bus.run, 0);
        chk("post_rst_din", bus.din, 0);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_pc", bus.pc, 0);
        exp_pc = 0;

`ifdef FETCH_STEP_EN
        bus.enable = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mem[exp_pc] = non_mvi(DW'($urandom));
            tick();
            tick();
            chk("no_step_busy", bus.busy, 0);
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            runs = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (bus.run) begin
                    runs++;
                    bus.done = 1'b1;
                end else begin
                    bus.done = 1'b0;
                end
            end
            exp_pc = (exp_pc + 1) % NW;
            chk("step_runs", runs, 1);
            chk("step_pc", bus.pc, exp_pc);
            chk("step_busy", bus.busy, 0);
        end
        bus.enable = 1'b0;
`else
        issue(9'o012, 9'd0, 1, 2, 0);
        for (int i = 1; i < 4; i++)
            issue(non_mvi(DW'($urandom)), 9'd0, 0, $urandom_range(0, 3), 0);
        issue(9'b001_011_000, 9'd77, 0, 3, 0);
        chk("mvi_pc6", exp_pc, 6);
        it = 0;
        while (it < 40 && !(exp_pc == 31 && it >= 10)) begin
            w = DW'($urandom);
            if ($urandom_range(0, 2) == 0) w[8:6] = 3'b001;
            if (exp_pc >= 30) w = non_mvi(w);
            issue(w, DW'($urandom), 0, $urandom_range(0, 3), 0);
            it++;
        end
        chk("reach_31", exp_pc, 31);
        issue(9'b001_011_000, 9'd5, 0, 2, 0);
        issue(non_mvi(DW'($urandom)), 9'd0, 0, 3, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_run", bus.run, 0);
            chk("idle_busy", bus.busy, 0);
        end
        chk("idle_pc", bus.pc, exp_pc);
`endif

        mem[exp_pc] = non_mvi(9'o321);
        bus.enable = 1'b1;
        runs = 0;
        for (int c = 0; c < 8 && runs == 0; c++) begin
            tick();
            if (bus.run) runs = 1;
        end
        chk("pre_rst_run", runs, 1);
        bus.enable = 1'b0;
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        chk("wrst_pc", bus.pc, 0);
        chk("wrst_run", bus.run, 0);
        chk("wrst_din", bus.din, 0);
        chk("wrst_busy", bus.busy, 0);
        rst = 1'b0;
        tick();
        chk("wrst2_din", bus.din, 0);
        chk("wrst2_busy", bus.busy, 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        chk("late_done_pc", bus.pc, 0);
        chk("late_done_busy", bus.busy, 0);
        chk("late_done_run", bus.run, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
